pipeline_ctrl: RTL

//   Central pipeline controller for the 5-stage MIPS core. Merges stage stall requests into the

---
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences exception flushes
// toward the exception vector, and raises a sticky watchdog flag on prolonged stalls.
module pipeline_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned WDOG_LIMIT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_req,
   input  logic [31:0] excp_epc,
   input  logic [4:0]  excp_code,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        excp_valid,
   output logic [31:0] epc_o,
   output logic [4:0]  cause_o,
   output logic        wdog_timeout
);

   localparam logic        RST_ENABLE = 1'b1;
   localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int unsigned WCW = $clog2(WDOG_LIMIT + 1);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t         state_q, state_d;
   logic [FCW-1:0] fcnt;
   logic [WCW-1:0] wcnt;
   logic           accept;
   logic           flush_done;

   always_comb begin
      stall = '0;
      if (rst != RST_ENABLE && state_q == S_RUN) begin
         if (stallreq_mem)
            stall = 6'b011111;
         else if (stallreq_ex)
            stall = 6'b001111;
         else if (stallreq_id)
            stall = 6'b000111;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      flush_done = 1'b0;
      case (state_q)
         S_RUN: begin
            if (excp_req) begin
               state_d = S_FLUSH;
               accept  = 1'b1;
            end
         end
         S_FLUSH: begin
            if (fcnt == '0) begin
               state_d    = S_RUN;
               flush_done = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE)
         state_q <= S_RUN;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         flush        <= 1'b0;
         new_pc       <= '0;
         excp_valid   <= 1'b0;
         epc_o        <= '0;
         cause_o      <= '0;
         wdog_timeout <= 1'b0;
         fcnt         <= '0;
         wcnt         <= '0;
      end else begin
         // excp_valid is a single-cycle pulse: only the accepting edge raises it
         excp_valid <= 1'b0;
         if (accept) begin
            flush      <= 1'b1;
            new_pc     <= EXC_VECTOR;
            epc_o      <= excp_epc;
            cause_o    <= excp_code;
            excp_valid <= 1'b1;
            fcnt       <= FCW'(FLUSH_CYCLES - 1);
         end else if (state_q == S_FLUSH) begin
            if (flush_done) begin
               flush  <= 1'b0;
               new_pc <= '0;
            end else begin
               fcnt <= fcnt - FCW'(1);
            end
         end

         // stall[0] is forced low in S_FLUSH, so the else branch also clears there
         if (state_q == S_RUN && stall[0]) begin
            if (wcnt != WCW'(WDOG_LIMIT))
               wcnt <= wcnt + WCW'(1);
            if (wcnt == WCW'(WDOG_LIMIT - 1))
               wdog_timeout <= 1'b1;
         end else begin
            wcnt <= '0;
         end
      end
   end

endmodule
